// File: rtl/reg_file_rename.sv
// reg_file_rename
//   Architectural register file with a rename-tag table. The decoder renames
//   rd to a ROB entry on issue and queries rs1/rs2, getting back either a
//   committed value or the ROB tag the source is waiting on. The ROB's commit
//   stream writes values and clears a tag only if it is still the current
//   owner of the register. Rollback clears every tag. Values always hold
//   committed state and are never rolled back.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global enable; low holds all state
//   rollback            mispredict flush: clears all busy/tags, drops issue
//   issue_*             rename of rd to issue_rob
//   rs1_*, rs2_*        combinational source queries (with commit forwarding)
//   commit_reg_*        committed register write from the ROB
//   debug_regs          flattened registered values, x31..x0
module reg_file_rename #(
    parameter int ROB_W = 4,
    parameter int XLEN  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 rollback,
    input  logic                 issue_config,
    input  logic [4:0]           issue_rd,
    input  logic [ROB_W-1:0]     issue_rob,
    input  logic [4:0]           rs1_id,
    output logic [XLEN-1:0]      rs1_value,
    output logic                 rs1_busy,
    output logic [ROB_W-1:0]     rs1_rob,
    input  logic [4:0]           rs2_id,
    output logic [XLEN-1:0]      rs2_value,
    output logic                 rs2_busy,
    output logic [ROB_W-1:0]     rs2_rob,
    input  logic                 commit_reg_config,
    input  logic [4:0]           commit_reg_id,
    input  logic [XLEN-1:0]      commit_reg_value,
    input  logic [ROB_W-1:0]     commit_reg_rob,
    output logic [32*XLEN-1:0]   debug_regs
);

    logic [31:0][XLEN-1:0]  value_q, value_d;
    logic [31:0]            busy_q,  busy_d;
    logic [31:0][ROB_W-1:0] tag_q,   tag_d;

    logic commit_hit;  // commit targets a live register whose tag it still owns
    assign commit_hit = commit_reg_config && (commit_reg_id != 5'd0) &&
                        busy_q[commit_reg_id] && (tag_q[commit_reg_id] == commit_reg_rob);

    always_comb begin
        value_d = value_q;
        busy_d  = busy_q;
        tag_d   = tag_q;
        if (rdy) begin
            // Commit first; a stale tag (younger writer owns rd) still writes
            // the committed value but leaves busy/tag alone.
            if (commit_reg_config && commit_reg_id != 5'd0) begin
                value_d[commit_reg_id] = commit_reg_value;
                if (commit_hit) begin
                    busy_d[commit_reg_id] = 1'b0;
                    tag_d[commit_reg_id]  = '0;
                end
            end
            // Issue afterwards so a same-cycle rename of the same rd wins.
            if (rollback) begin
                busy_d = '0;
                tag_d  = '0;
            end else if (issue_config && issue_rd != 5'd0) begin
                busy_d[issue_rd] = 1'b1;
                tag_d[issue_rd]  = issue_rob;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
            busy_q  <= '0;
            tag_q   <= '0;
        end else begin
            value_q <= value_d;
            busy_q  <= busy_d;
            tag_q   <= tag_d;
        end
    end

    // Source lookup. Same-cycle commit is forwarded; same-cycle issue is not,
    // since an instruction's sources are read before its own rename.
    always_comb begin
        rs1_value = '0;
        rs1_busy  = 1'b0;
        rs1_rob   = '0;
        if (rs1_id != 5'd0) begin
            if (commit_hit && commit_reg_id == rs1_id) begin
                rs1_value = commit_reg_value;
            end else begin
                rs1_value = value_q[rs1_id];
                rs1_busy  = busy_q[rs1_id];
                rs1_rob   = busy_q[rs1_id] ? tag_q[rs1_id] : '0;
            end
        end
    end

    always_comb begin
        rs2_value = '0;
        rs2_busy  = 1'b0;
        rs2_rob   = '0;
        if (rs2_id != 5'd0) begin
            if (commit_hit && commit_reg_id == rs2_id) begin
                rs2_value = commit_reg_value;
            end else begin
                rs2_value = value_q[rs2_id];
                rs2_busy  = busy_q[rs2_id];
                rs2_rob   = busy_q[rs2_id] ? tag_q[rs2_id] : '0;
            end
        end
    end

    for (genvar i = 0; i < 32; i++) begin : g_dbg
        assign debug_regs[XLEN*i +: XLEN] = value_q[i];
    end

endmodule

// File: tb/tb_reg_file_rename.sv
// tb_reg_file_rename
//   Table-driven directed bench for reg_file_rename. Each row drives one
//   cycle of inputs, checks the combinational query outputs mid-cycle, then
//   lets the clock edge apply the update. Debug-register snapshots are
//   checked between row groups.
module tb_reg_file_rename;

    localparam int ROB_W = 4;
    localparam int XLEN  = 32;

    logic                clk = 1'b0;
    logic                rst, rdy, rollback, issue_config, commit_reg_config;
    logic [4:0]          issue_rd, rs1_id, rs2_id, commit_reg_id;
    logic [ROB_W-1:0]    issue_rob, commit_reg_rob, rs1_rob, rs2_rob;
    logic [XLEN-1:0]     rs1_value, rs2_value, commit_reg_value;
    logic                rs1_busy, rs2_busy;
    logic [32*XLEN-1:0]  debug_regs;

    always #5 clk = ~clk;

    reg_file_rename #(.ROB_W(ROB_W), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .issue_config(issue_config), .issue_rd(issue_rd), .issue_rob(issue_rob),
        .rs1_id(rs1_id), .rs1_value(rs1_value), .rs1_busy(rs1_busy), .rs1_rob(rs1_rob),
        .rs2_id(rs2_id), .rs2_value(rs2_value), .rs2_busy(rs2_busy), .rs2_rob(rs2_rob),
        .commit_reg_config(commit_reg_config), .commit_reg_id(commit_reg_id),
        .commit_reg_value(commit_reg_value), .commit_reg_rob(commit_reg_rob),
        .debug_regs(debug_regs)
    );

    typedef struct {
        logic             rst, rdy, rb;
        logic             iss;
        logic [4:0]       rd;
        logic [3:0]       irob;
        logic             cm;
        logic [4:0]       cid;
        logic [31:0]      cval;
        logic [3:0]       crob;
        logic [4:0]       r1, r2;
        logic             chk;
        logic [31:0]      e1v;
        logic             e1b;
        logic [3:0]       e1r;
        logic [31:0]      e2v;
        logic             e2b;
        logic [3:0]       e2r;
    } vec_t;

    vec_t vecs[$];
    int total = 0;
    int bad   = 0;

    function automatic vec_t mk(input logic rst_i, input logic rdy_i, input logic rb_i,
                                input logic iss_i, input int rd_i, input int irob_i,
                                input logic cm_i, input int cid_i, input int cval_i, input int crob_i,
                                input int r1_i, input int r2_i, input logic chk_i,
                                input int e1v_i, input logic e1b_i, input int e1r_i,
                                input int e2v_i, input logic e2b_i, input int e2r_i);
        vec_t v;
        v.rst = rst_i; v.rdy = rdy_i; v.rb = rb_i;
        v.iss = iss_i; v.rd = rd_i[4:0]; v.irob = irob_i[3:0];
        v.cm = cm_i; v.cid = cid_i[4:0]; v.cval = cval_i; v.crob = crob_i[3:0];
        v.r1 = r1_i[4:0]; v.r2 = r2_i[4:0]; v.chk = chk_i;
        v.e1v = e1v_i; v.e1b = e1b_i; v.e1r = e1r_i[3:0];
        v.e2v = e2v_i; v.e2b = e2b_i; v.e2r = e2r_i[3:0];
        return v;
    endfunction

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        rst = v.rst; rdy = v.rdy; rollback = v.rb;
        issue_config = v.iss; issue_rd = v.rd; issue_rob = v.irob;
        commit_reg_config = v.cm; commit_reg_id = v.cid;
        commit_reg_value = v.cval; commit_reg_rob = v.crob;
        rs1_id = v.r1; rs2_id = v.r2;
        #1;
        if (v.chk) begin
            total++;
            if (rs1_value !== v.e1v || rs1_busy !== v.e1b || rs1_rob !== v.e1r ||
                rs2_value !== v.e2v || rs2_busy !== v.e2b || rs2_rob !== v.e2r) begin
                bad++;
                $display("FAIL row%0d query: got rs1=%h/%b/%h rs2=%h/%b/%h want rs1=%h/%b/%h rs2=%h/%b/%h",
                         idx, rs1_value, rs1_busy, rs1_rob, rs2_value, rs2_busy, rs2_rob,
                         v.e1v, v.e1b, v.e1r, v.e2v, v.e2b, v.e2r);
            end
        end
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) apply(vecs[i], i);
        // Park inputs idle and let the last row's edge land before snapshots.
        @(negedge clk);
        rst = 1'b0; rdy = 1'b1; rollback = 1'b0; issue_config = 1'b0; commit_reg_config = 1'b0;
        rs1_id = '0; rs2_id = '0;
        #1;
    endtask

    task automatic chk_dbg(input string name, input int reg_i, input logic [31:0] exp);
        total++;
        if (debug_regs[XLEN*reg_i +: XLEN] !== exp) begin
            bad++;
            $display("FAIL %s: x%0d got %h want %h", name, reg_i, debug_regs[XLEN*reg_i +: XLEN], exp);
        end
    endtask

    task automatic chk_dbg_zero(input string name);
        total++;
        if (debug_regs !== '0) begin
            bad++;
            $display("FAIL %s: debug_regs not all zero, x1=%h x3=%h", name,
                     debug_regs[XLEN*1 +: XLEN], debug_regs[XLEN*3 +: XLEN]);
        end
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; rollback = 1'b0; issue_config = 1'b0; issue_rd = '0; issue_rob = '0;
        commit_reg_config = 1'b0; commit_reg_id = '0; commit_reg_value = '0; commit_reg_rob = '0;
        rs1_id = '0; rs2_id = '0;

        //          rst rdy rb  iss rd irob cm  cid cval    crob r1 r2 chk  e1v     e1b e1r e2v   e2b e2r
        vecs.push_back(mk(1, 1, 0,  0, 0, 0,  0, 0, 0,      0,  0, 0, 0,  0,      0, 0,  0,    0, 0)); // 0 reset
        vecs.push_back(mk(0, 1, 0,  0, 0, 0,  0, 0, 0,      0,  5, 0, 1,  0,      0, 0,  0,    0, 0)); // 1 post-reset
        vecs.push_back(mk(0, 1, 0,  1, 3, 7,  0, 0, 0,      0,  3, 0, 1,  0,      0, 0,  0,    0, 0)); // 2 issue not fwd
        vecs.push_back(mk(0, 1, 0,  0, 0, 0,  0, 0, 0,      0,  3, 3, 1,  0,      1, 7,  0,    1, 7)); // 3 pending
        vecs.push_back(mk(0, 1, 0,  0, 0, 0,  1, 3, 'h1234, 7,  3, 0, 1,  'h1234, 0, 0,  0,    0, 0)); // 4 commit fwd
        vecs.push_back(mk(0, 1, 0,  0, 0, 0,  0, 0, 0,      0,  3, 0, 1,  'h1234, 0, 0,  0,    0, 0)); // 5 registered
        vecs.push_back(mk(0, 1, 0,  1, 4, 2,  0, 0, 0,      0,  4, 0, 1,  0,      0, 0,  0,    0, 0)); // 6
        vecs.push_back(mk(0, 1, 0,  1, 4, 9,  0, 0, 0,      0,  4, 0, 1,  0,      1, 2,  0,    0, 0)); // 7 re-rename
        vecs.push_back(mk(0, 1, 0,  0, 0, 0,  1, 4, 'hAA,   2,  4, 0, 1,  0,      1, 9,  0,    0, 0)); // 8 stale commit
        vecs.push_back(mk(0, 1, 0,  0, 0, 0,  0, 0, 0,      0,  4, 0, 1,  'hAA,   1, 9,  0,    0, 0)); // 9
        vecs.push_back(mk(0, 1, 0,  1, 6, 3,  1, 6, 'h55,   1,  6, 0, 1,  0,      0, 0,  0,    0, 0)); // 10 issue+commit
        vecs.push_back(mk(0, 1, 0,  0, 0, 0,  0, 0, 0,      0,  6, 0, 1,  'h55,   1, 3,  0,    0, 0)); // 11
        vecs.push_back(mk(0, 1, 0,  1, 1, 4,  0, 0, 0,      0,  1, 0, 1,  0,      0, 0,  0,    0, 0)); // 12
        vecs.push_back(mk(0, 1, 0,  1, 2, 5,  0, 0, 0,      0,  0, 0, 0,  0,      0, 0,  0,    0, 0)); // 13
        vecs.push_back(mk(0, 1, 0,  1, 5, 6,  0, 0, 0,      0,  1, 2, 1,  0,      1, 4,  0,    1, 5)); // 14
        vecs.push_back(mk(0, 1, 1,  1, 8, 7,  1, 1, 'h10,   4,  5, 1, 1,  0,      1, 6,  'h10, 0, 0)); // 15 rollback
        vecs.push_back(mk(0, 1, 0,  0, 0, 0,  0, 0, 0,      0,  1, 8, 1,  'h10,   0, 0,  0,    0, 0)); // 16
        vecs.push_back(mk(0, 1, 0,  0, 0, 0,  0, 0, 0,      0,  4, 6, 1,  'hAA,   0, 0,  'h55, 0, 0)); // 17
        vecs.push_back(mk(0, 1, 0,  0, 0, 0,  0, 0, 0,      0,  5, 2, 1,  0,      0, 0,  0,    0, 0)); // 18
        vecs.push_back(mk(0, 1, 0,  1, 0, 3,  1, 0, 'hFF,   0,  0, 0, 1,  0,      0, 0,  0,    0, 0)); // 19 x0
        vecs.push_back(mk(0, 1, 0,  0, 0, 0,  0, 0, 0,      0,  0, 0, 1,  0,      0, 0,  0,    0, 0)); // 20
        vecs.push_back(mk(0, 1, 0,  1, 2, 5,  0, 0, 0,      0,  2, 0, 1,  0,      0, 0,  0,    0, 0)); // 21
        vecs.push_back(mk(0, 0, 0,  1, 2, 8,  1, 2, 'h99,   6,  2, 0, 1,  0,      1, 5,  0,    0, 0)); // 22 rdy=0
        vecs.push_back(mk(0, 1, 0,  0, 0, 0,  0, 0, 0,      0,  2, 2, 1,  0,      1, 5,  0,    1, 5)); // 23 held
        vecs.push_back(mk(1, 0, 0,  0, 0, 0,  0, 0, 0,      0,  3, 0, 1,  'h1234, 0, 0,  0,    0, 0)); // 24 rst
        vecs.push_back(mk(0, 1, 0,  0, 0, 0,  0, 0, 0,      0,  3, 2, 1,  0,      0, 0,  0,    0, 0)); // 25 cleared

        run_rows(0, 1);
        chk_dbg_zero("dbg_after_reset");

        run_rows(2, 18);
        chk_dbg("dbg_mid", 1, 32'h10);
        chk_dbg("dbg_mid", 3, 32'h1234);
        chk_dbg("dbg_mid", 4, 32'hAA);
        chk_dbg("dbg_mid", 6, 32'h55);
        chk_dbg("dbg_mid", 8, 32'h0);

        run_rows(19, 23);
        chk_dbg("dbg_x0", 0, 32'h0);
        chk_dbg("dbg_rdy_hold", 2, 32'h0);

        run_rows(24, 25);
        chk_dbg_zero("dbg_after_midrun_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
